instruction_sequencer: RTL and testbench

Front end of the 4-bit nano-processor: program counter, program-memory fetch, instruction register and decoder. Drives the computational unit's select/enable controls (source_sel, reg_en, i_sel, x_sel, y_sel, ir_nibble, sync_reset) and consumes its r_eq_0 flag for conditional jumps. Two-stage pipeline: fetch (PC -> pm_address, pm_data -> IR), then decode/execute from IR.

---
 rtl/instruction_sequencer.sv | 115 +++++++++++
 tb/tb_instruction_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Nano-processor front end: PC, fetch into IR, and decode of IR into compute-unit controls.
// Optional build macro SEQ_HOLD_EN adds a 'hold' input that freezes fetch and gates writes.
module instruction_sequencer #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
`ifdef SEQ_HOLD_EN
  input  logic            hold,
`endif
  input  logic [7:0]      pm_data,
  input  logic            r_eq_0,
  output logic [PC_W-1:0] pm_address,
  output logic [7:0]      ir,
  output logic [3:0]      ir_nibble,
  output logic [3:0]      source_sel,
  output logic [8:0]      reg_en,
  output logic            i_sel,
  output logic            x_sel,
  output logic            y_sel,
  output logic            sync_reset
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            sync_reset_q, sync_reset_d;

  logic            stall;
  logic            is_load, is_move, is_alu, is_jmp, jump_taken;
  logic [2:0]      dst, src;
  logic [8:0]      dec_en;

`ifdef SEQ_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    is_load    = ~ir_q[7];
    is_move    = (ir_q[7:6] == 2'b10);
    is_alu     = (ir_q[7:5] == 3'b110);
    is_jmp     = (ir_q[7:5] == 3'b111);
    dst        = is_load ? ir_q[6:4] : ir_q[5:3];
    src        = ir_q[2:0];
    source_sel = 4'd0;
    dec_en     = 9'h000;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;

    if (is_load)
      source_sel = 4'd8;
    else if (is_move)
      source_sel = (dst == src) ? 4'd9 : {1'b0, src};

    if (is_alu) begin
      dec_en[4] = 1'b1;
      x_sel     = ir_q[4];
      y_sel     = ir_q[3];
    end

    if (is_load || is_move) begin
      // dst code 4 is the output register, which lives at the top enable bit
      dec_en = (dst == 3'd4) ? 9'h100 : (9'h001 << dst);
      // any data-memory access other than a write of i post-increments i by m
      if (dst != 3'd6 && (dst == 3'd7 || (is_move && src == 3'd7))) begin
        dec_en[6] = 1'b1;
        i_sel     = 1'b1;
      end
    end

    jump_taken = ir_valid_q & is_jmp & (~ir_q[4] | ~r_eq_0) & ~stall;
    reg_en     = (ir_valid_q & ~stall) ? dec_en : 9'h000;
  end

  always_comb begin
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    sync_reset_d = 1'b0;
    if (!stall) begin
      ir_d = pm_data;
      if (jump_taken) begin
        // delay-slot word is loaded but marked invalid so it never writes
        pc_d       = PC_W'(ir_q[3:0]);
        ir_valid_d = 1'b0;
      end else begin
        pc_d       = pc_q + PC_W'(1);
        ir_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q         <= '0;
      ir_q         <= 8'h00;
      ir_valid_q   <= 1'b0;
      sync_reset_q <= 1'b1;
    end else begin
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      sync_reset_q <= sync_reset_d;
    end
  end

  assign pm_address = pc_q;
  assign ir         = ir_q;
  assign ir_nibble  = ir_q[3:0];
  assign sync_reset = sync_reset_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer: program memory array plus an instruction-level
// reference model (pc, ir, valid flag) and a table-driven decode of the instruction set.
module tb_instruction_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       r_eq_0 = 1'b0;
  logic [7:0] pm_data;
  logic [3:0] pm_address;
  logic [7:0] ir;
  logic [3:0] ir_nibble, source_sel;
  logic [8:0] reg_en;
  logic       i_sel, x_sel, y_sel, sync_reset;
`ifdef SEQ_HOLD_EN
  logic       hold = 1'b0;
`endif

  logic [7:0] mem [16];
  assign pm_data = mem[pm_address];

  instruction_sequencer #(.PC_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef SEQ_HOLD_EN
    .hold(hold),
`endif
    .pm_data(pm_data), .r_eq_0(r_eq_0), .pm_address(pm_address), .ir(ir),
    .ir_nibble(ir_nibble), .source_sel(source_sel), .reg_en(reg_en), .i_sel(i_sel),
    .x_sel(x_sel), .y_sel(y_sel), .sync_reset(sync_reset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int         m_pc;
  logic [7:0] m_ir;
  bit         m_valid, m_sr;
  int         dst_bit [8] = '{0, 1, 2, 3, 8, 5, 6, 7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // instruction-level meaning of one word: which registers it writes and which selects it sets
  task automatic ref_dec(input logic [7:0] w, output logic [8:0] en, output logic [3:0] ss,
                         output logic is, output logic xs, output logic ys);
    int  d, s;
    bit  wr;
    en = 0; ss = 0; is = 0; xs = 0; ys = 0; wr = 0; d = 0; s = -1;
    if (w < 8'h80) begin
      d = int'(w[6:4]); ss = 4'd8; wr = 1;
    end else if (w < 8'hC0) begin
      d = int'(w[5:3]); s = int'(w[2:0]); wr = 1;
      ss = (d == s) ? 4'd9 : 4'(s);
    end else if (w < 8'hE0) begin
      en = 9'h010; xs = w[4]; ys = w[3];
    end
    if (wr) begin
      en = 9'(1 << dst_bit[d]);
      if (d != 6 && (d == 7 || s == 7)) begin
        en = en | 9'h040;
        is = 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [8:0] en;
    logic [3:0] ss;
    logic       is, xs, ys;
    ref_dec(m_ir, en, ss, is, xs, ys);
    chk("pc", 32'(pm_address), 32'(m_pc));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("nibble", 32'(ir_nibble), 32'(m_ir[3:0]));
    chk("sync_reset", 32'(sync_reset), 32'(m_sr));
    chk("reg_en", 32'(reg_en), m_valid ? 32'(en) : 32'd0);
    if (m_valid) begin
      chk("source_sel", 32'(source_sel), 32'(ss));
      chk("i_sel", 32'(i_sel), 32'(is));
      chk("x_sel", 32'(x_sel), 32'(xs));
      chk("y_sel", 32'(y_sel), 32'(ys));
      // hand-worked encodings from the instruction set, independent of the decode table
      case (m_ir)
        8'h05: begin chk("ld_x0_en", 32'(reg_en), 32'h001); chk("ld_x0_src", 32'(source_sel), 32'd8); end
        8'h8A: begin chk("mv_x1_en", 32'(reg_en), 32'h002); chk("mv_x1_src", 32'(source_sel), 32'd2); end
        8'h92: begin chk("mv_pins_en", 32'(reg_en), 32'h004); chk("mv_pins_src", 32'(source_sel), 32'd9); end
        8'hB8: begin chk("dm_wr_en", 32'(reg_en), 32'h0C0); chk("dm_wr_isel", 32'(i_sel), 32'd1); end
        8'hB7: begin chk("i_dm_en", 32'(reg_en), 32'h040); chk("i_dm_src", 32'(source_sel), 32'd7); end
        8'hDA: begin chk("alu_en", 32'(reg_en), 32'h010); chk("alu_xy", 32'({x_sel, y_sel}), 32'd3); end
        default: ;
      endcase
    end
  endtask

  task automatic model_step(input logic req);
    bit         jmp;
    logic [7:0] nxt;
    jmp = m_valid && (m_ir >= 8'hE0) && (!m_ir[4] || !req);
    nxt = mem[m_pc];
    m_sr = 0;
    if (jmp) begin
      m_pc    = int'(m_ir[3:0]);
      m_valid = 0;
    end else begin
      m_pc    = (m_pc + 1) % 16;
      m_valid = 1;
    end
    m_ir = nxt;
  endtask

  // req: 0/1 forces r_eq_0, 2 randomizes it every cycle
  task automatic step(input int n, input int req);
    repeat (n) begin
      r_eq_0 = (req == 2) ? 1'($urandom_range(0, 1)) : 1'(req);
      check_outputs();
      model_step(r_eq_0);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pm_address), 32'd0);
    chk("rst_reg_en", 32'(reg_en), 32'd0);
    chk("rst_sync", 32'(sync_reset), 32'd1);
    m_pc = 0; m_ir = 8'h00; m_valid = 0; m_sr = 1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = 8'h05;
    #2;
    do_reset();
    step(22, 2);

    // straight-line moves/ALU, then jump at 6 back to 3
    mem[0] = 8'h8A; mem[1] = 8'h92; mem[2] = 8'hB8; mem[3] = 8'hB7;
    mem[4] = 8'hDA; mem[5] = 8'h05; mem[6] = 8'hE3;
    do_reset();
    step(14, 2);

    // jnz at 1 with a jump in its delay slot
    for (int a = 0; a < 16; a++) mem[a] = 8'h05;
    mem[1] = 8'hF3; mem[2] = 8'hE8; mem[4] = 8'h8A;
    do_reset();
    step(8, 1);
    do_reset();
    step(8, 0);

    for (int k = 0; k < 25; k++) begin
      for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
      do_reset();
      step(20 + int'($urandom_range(0, 30)), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
